// File: rtl/token_tx_ctrl.sv
// Token packet transmit sequencer: serialises SYNC, PID/check-PID, address,
// endpoint, inverted CRC5 and an EOP marker, and sequences the external CRC5 unit.
module token_tx_ctrl #(
  parameter int unsigned SYNC_BITS = 8
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] pid,
  input  logic [6:0] addr,
  input  logic [3:0] endp,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic       eop,
  output logic       crc_clear,
  output logic       crc_shift,
  output logic       crc_bit,
  input  logic [4:0] crc_rem,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_ADDR,
    ST_ENDP,
    ST_CRC,
    ST_EOP
  } state_e;

  localparam logic [3:0] SYNC_LAST = 4'(SYNC_BITS - 1);

  state_e     state_q, state_d;
  state_e     nxt;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] pid_q, pid_d;
  logic [6:0] addr_q, addr_d;
  logic [3:0] endp_q, endp_d;
  logic       transfer;
  logic       last;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pid_q   <= '0;
      addr_q  <= '0;
      endp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pid_q   <= pid_d;
      addr_q  <= addr_d;
      endp_q  <= endp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pid_d     = pid_q;
    addr_d    = addr_q;
    endp_d    = endp_q;
    nxt       = ST_IDLE;
    last      = 1'b0;
    req_ready = 1'b0;
    bit_out   = 1'b0;
    eop       = 1'b0;
    crc_clear = 1'b0;
    crc_shift = 1'b0;
    crc_bit   = 1'b0;
    busy      = (state_q != ST_IDLE);
    bit_valid = (state_q != ST_IDLE);
    transfer  = bit_valid && bit_ready;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        // rst_b gate keeps crc_clear low while reset is held with a pending request
        if (req_valid && rst_b) begin
          crc_clear = 1'b1;
          pid_d     = pid;
          addr_d    = addr;
          endp_d    = endp;
          cnt_d     = '0;
          state_d   = ST_SYNC;
        end
      end
      ST_SYNC: begin
        bit_out = (cnt_q == SYNC_LAST);
        last    = (cnt_q == SYNC_LAST);
        nxt     = ST_PID;
      end
      ST_PID: begin
        // upper half of the field is the bitwise complement of the PID
        bit_out = cnt_q[2] ? ~pid_q[cnt_q[1:0]] : pid_q[cnt_q[1:0]];
        last    = (cnt_q == 4'd7);
        nxt     = ST_ADDR;
      end
      ST_ADDR: begin
        bit_out   = addr_q[cnt_q[2:0]];
        crc_shift = transfer;
        crc_bit   = bit_out;
        last      = (cnt_q == 4'd6);
        nxt       = ST_ENDP;
      end
      ST_ENDP: begin
        bit_out   = endp_q[cnt_q[1:0]];
        crc_shift = transfer;
        crc_bit   = bit_out;
        last      = (cnt_q == 4'd3);
        nxt       = ST_CRC;
      end
      ST_CRC: begin
        bit_out = ~crc_rem[3'd4 - cnt_q[2:0]];
        last    = (cnt_q == 4'd4);
        nxt     = ST_EOP;
      end
      ST_EOP: begin
        eop  = 1'b1;
        last = 1'b1;
        nxt  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (transfer) begin
      if (last) begin
        state_d = nxt;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_token_tx_ctrl.sv
// Directed bench for token_tx_ctrl with a behavioural CRC5 unit attached.
module tb_token_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] pid;
  logic [6:0] addr;
  logic [3:0] endp;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;
  logic       eop;
  logic       crc_clear;
  logic       crc_shift;
  logic       crc_bit;
  logic [4:0] crc_rem;
  logic       busy;

  logic [4:0] crc_q;
  logic       force_crc;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  token_tx_ctrl #(.SYNC_BITS(8)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .pid       (pid),
    .addr      (addr),
    .endp      (endp),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .eop       (eop),
    .crc_clear (crc_clear),
    .crc_shift (crc_shift),
    .crc_bit   (crc_bit),
    .crc_rem   (crc_rem),
    .busy      (busy)
  );

  // USB CRC5, polynomial x^5 + x^2 + 1, serial LSB-first data
  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    logic fb;
    fb = b ^ c[4];
    return {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
  endfunction

  // transmitted CRC field, element [4] goes on the wire first
  function automatic logic [4:0] crc_field(input logic [6:0] a, input logic [3:0] e);
    logic [4:0] c;
    c = 5'h1F;
    for (int i = 0; i < 7; i++) c = crc5_step(c, a[i]);
    for (int i = 0; i < 4; i++) c = crc5_step(c, e[i]);
    return ~c;
  endfunction

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)         crc_q <= '0;
    else if (crc_clear) crc_q <= '1;
    else if (crc_shift) crc_q <= crc5_step(crc_q, crc_bit);
  end

  assign crc_rem = force_crc ? 5'b01010 : crc_q;

  function automatic logic [31:0] build_stream(input logic [3:0] p, input logic [6:0] a,
                                               input logic [3:0] e, input logic [4:0] crcf);
    logic [31:0] s;
    s        = '0;
    s[7]     = 1'b1;
    s[11:8]  = p;
    s[15:12] = ~p;
    s[22:16] = a;
    s[26:23] = e;
    for (int j = 0; j < 5; j++) s[27 + j] = crcf[4 - j];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Entered during an IDLE cycle (after its negedge); returns during the IDLE
  // cycle following EOP, or just after a reset release when abort_at >= 0.
  task automatic send_packet(input logic [3:0] p, input logic [6:0] a, input logic [3:0] e,
                             input logic [4:0] crcf, input bit stall_mode, input bit hold_valid,
                             input logic [3:0] np, input logic [6:0] na, input logic [3:0] ne,
                             input bit next_valid, input int abort_at);
    logic [31:0] stream;
    int          idx;
    int          cyc;
    int          shifts;
    int          stalls;
    bit          ready_now;
    bit          done;

    stream    = build_stream(p, a, e, crcf);
    pid       = p;
    addr      = a;
    endp      = e;
    req_valid = 1'b1;
    bit_ready = 1'b1;
    #1;
    chk("idle_req_ready", req_ready, 1);
    chk("accept_crc_clear", crc_clear, 1);
    chk("idle_bit_valid", bit_valid, 0);

    idx = 0; cyc = 0; shifts = 0; stalls = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req_valid = hold_valid;
      if (hold_valid) begin
        pid  = np;
        addr = na;
        endp = ne;
      end
      ready_now = stall_mode ? ((cyc % 4 == 1) || (cyc % 4 == 0)) : 1'b1;
      bit_ready = ready_now;
      #1;
      if (abort_at >= 0 && idx == abort_at) begin
        rst_b = 1'b0;
        #1;
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_eop", eop, 0);
        chk("rst_crc_shift", crc_shift, 0);
        chk("rst_bit_out", bit_out, 0);
        @(negedge clk);
        rst_b     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("rst_rel_req_ready", req_ready, 1);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          #1;
          chk("rst_no_eop", eop, 0);
          chk("rst_idle_bit_valid", bit_valid, 0);
        end
        return;
      end
      chk("busy", busy, 1);
      chk("bit_valid", bit_valid, 1);
      chk("req_ready_busy", req_ready, 0);
      chk("crc_clear_busy", crc_clear, 0);
      chk("eop", eop, idx == 32);
      if (idx < 32) chk("bit_out", bit_out, stream[idx]);
      else          chk("eop_bit_out", bit_out, 0);
      chk("crc_shift", crc_shift, ready_now && idx >= 16 && idx < 27);
      if (crc_shift) begin
        shifts++;
        chk("crc_bit", crc_bit, stream[idx]);
      end
      if (!ready_now) stalls++;
      else begin
        if (idx == 32) done = 1;
        idx++;
      end
    end
    chk("packet_done", done, 1);
    chk("eop_cycle", cyc, 33 + stalls);
    chk("crc_shift_count", shifts, 11);

    @(negedge clk);
    req_valid = next_valid;
    #1;
    chk("post_req_ready", req_ready, 1);
    chk("post_busy", busy, 0);
    chk("post_bit_valid", bit_valid, 0);
    chk("post_crc_clear", crc_clear, next_valid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b     = 1'b0;
    req_valid = 1'b0;
    pid       = '0;
    addr      = '0;
    endp      = '0;
    bit_ready = 1'b0;
    force_crc = 1'b0;
    #2;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_bit_valid", bit_valid, 0);
    chk("reset_bit_out", bit_out, 0);
    chk("reset_eop", eop, 0);
    chk("reset_crc_clear", crc_clear, 0);
    chk("reset_crc_shift", crc_shift, 0);
    chk("reset_crc_bit", crc_bit, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);

    // IN token, addr 15h endp Eh: remainder 01000, transmitted 1,0,1,1,1
    send_packet(4'b1001, 7'h15, 4'hE, 5'b10111, 0, 0, '0, '0, '0, 0, -1);

    // CRC unit pinned at 01010: field must be 1,0,1,0,1
    force_crc = 1'b1;
    send_packet(4'b0001, 7'h7F, 4'h3, 5'b10101, 0, 0, '0, '0, '0, 0, -1);
    force_crc = 1'b0;

    // backpressure 1,0,0,1 repeating
    send_packet(4'b1101, 7'h2A, 4'h5, crc_field(7'h2A, 4'h5), 1, 0, '0, '0, '0, 0, -1);

    // request held with new fields while busy, then back-to-back packets
    send_packet(4'b1001, 7'h01, 4'h1, crc_field(7'h01, 4'h1), 0, 1,
                4'b0101, 7'h55, 4'hA, 1, -1);
    send_packet(4'b0101, 7'h55, 4'hA, crc_field(7'h55, 4'hA), 0, 0, '0, '0, '0, 1, -1);
    send_packet(4'b1001, 7'h15, 4'hE, 5'b10111, 1, 0, '0, '0, '0, 0, -1);

    // reset mid-ADDR, then a clean packet
    send_packet(4'b0101, 7'h33, 4'h2, crc_field(7'h33, 4'h2), 0, 0, '0, '0, '0, 0, 19);
    send_packet(4'b1001, 7'h15, 4'hE, 5'b10111, 0, 0, '0, '0, '0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/token_tx_ctrl.md
# token_tx_ctrl

Transmit-side sequencer for USB token packets (OUT/IN/SETUP/SOF-style 11-bit payload). It accepts one token request, drives the shared CRC5 remainder unit (clear, per-bit shift, bit value) and emits the packet as a serial LSB-first bit stream with a valid/ready handshake toward the bit-stuffer/NRZI stage: SYNC, PID, check-PID, address, endpoint, inverted CRC5, then an EOP marker. It owns CRC5 sequencing; the CRC5 unit itself is external.

## Interface
- SYNC_BITS, 8, SYNC field length; pattern is SYNC_BITS-1 zeros then a single one.
- clk  in  1  clock; all state updates on rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req_valid  in  1  token request present.
- req_ready  out  1  controller accepts a request this cycle.
- pid  in  4  PID code, sampled on accept.
- addr  in  7  device address, sampled on accept.
- endp  in  4  endpoint number, sampled on accept.
- bit_out  out  1  current serial bit.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  downstream consumes bit this cycle.
- eop  out  1  end-of-packet marker, qualified by bit_valid.
- crc_clear  out  1  one-cycle pulse: CRC5 unit loads all-ones.
- crc_shift  out  1  CRC5 unit shifts crc_bit this cycle.
- crc_bit  out  1  data bit fed to CRC5 unit.
- crc_rem  in  5  CRC5 remainder, crc_rem[4] = MSB.
- busy  out  1  packet in progress (state != IDLE).

## Operation
- States: IDLE, SYNC, PID, ADDR, ENDP, CRC, EOP. A 4-bit bit counter indexes the field.
- IDLE: req_ready=1. req_valid&&req_ready latches pid/addr/endp, pulses crc_clear, counter=0, next SYNC.
- Transfer = bit_valid && bit_ready. Counter and state advance only on a transfer; otherwise everything holds (bit_out stable while bit_valid && !bit_ready).
- SYNC: bit_out = (cnt==SYNC_BITS-1); after SYNC_BITS transfers -> PID.
- PID: 8 bits; cnt 0..3 send pid[cnt], cnt 4..7 send ~pid[cnt-4] -> ADDR.
- ADDR: 7 bits addr[0]..addr[6] -> ENDP. ENDP: 4 bits endp[0]..endp[3] -> CRC.
- In ADDR/ENDP: crc_shift = transfer, crc_bit = bit_out. crc_shift=0 in all other states.
- CRC: 5 bits, bit_out = ~crc_rem[4-cnt] (inverted remainder, MSB first). CRC5 unit is not shifted, so crc_rem is stable throughout.
- EOP: bit_valid=1, eop=1, bit_out=0; on transfer -> IDLE.
- bit_valid=1 in every state except IDLE. eop=1 only in EOP.
- Requests while busy are not accepted (req_ready=0); the requester holds them.
- Reset at any point (async): state IDLE, counter 0, latched fields 0, all outputs at reset values; partial packet discarded, no EOP emitted.

## Timing
- Reset values: req_ready=1, bit_valid=0, bit_out=0, eop=0, crc_clear=0, crc_shift=0, crc_bit=0, busy=0.
- Accept at edge k: crc_clear high during cycle k only (combinational from accept); bit_valid first high in cycle k+1.
- With bit_ready held high: 32 payload bits (SYNC_BITS=8) in cycles k+1..k+32, EOP in k+33, req_ready high again in k+34. Minimum one IDLE cycle between packets.
- crc_rem must reflect all 11 shifts by the first CRC cycle (CRC unit updates on the edge of the shift cycle).
- Each bit_ready low cycle extends the packet by exactly one cycle.

## Test plan
- Reset: assert rst_b=0 mid-ADDR with bit_ready=1 -> same cycle bit_valid=0, busy=0; after release req_ready=1, no eop seen.
- Basic IN token: pid=4'b1001, addr=7'h15, endp=4'hE, bit_ready=1 -> stream 0000000 1, 1001 0110, 1010100, 0111, then ~crc_rem MSB first, eop in cycle k+33; crc_clear exactly once at k.
- CRC handoff: bench CRC model forced to crc_rem=5'b01010 -> CRC field bits 1,0,1,0,1; crc_shift high exactly 11 cycles with crc_bit matching addr then endp bits LSB-first.
- Backpressure: toggle bit_ready 1,0,0,1 repeatedly -> bit_out stable while stalled, no bit duplicated/dropped, total 33 transfers, crc_shift never high on stalled cycles.
- Busy request: hold req_valid=1 with new fields during a packet -> not accepted until IDLE; second packet starts cycle k+35, carries the new fields.
- Back-to-back with req_valid always high -> exactly one IDLE cycle between EOP and next SYNC first bit.
